// File: rtl/gmii_tx_framer_if.sv
// Signal bundle for gmii_tx_framer: TX FIFO head, length handshake and GMII pins.
// The master modport is the framer's view; slave is the surrounding logic.
interface gmii_tx_framer_if #(
    parameter int LEN_W = 11
);
    logic [7:0]       fifo_data;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [LEN_W-1:0] word_count;
    logic             word_count_ready;
    logic             word_count_ack;
    logic [7:0]       gmii_tx_data;
    logic             gmii_tx_en;
    logic             gmii_tx_er;

    modport master (
        input  fifo_data, fifo_empty, word_count, word_count_ready,
        output fifo_rd, word_count_ack, gmii_tx_data, gmii_tx_en, gmii_tx_er
    );

    modport slave (
        output fifo_data, fifo_empty, word_count, word_count_ready,
        input  fifo_rd, word_count_ack, gmii_tx_data, gmii_tx_en, gmii_tx_er
    );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, zero pad, optional CRC-32 FCS, IFG.
// Define GMII_TX_FCS_EN to append the 4-byte FCS; otherwise upstream supplies it.
module gmii_tx_framer #(
    parameter int LEN_W        = 11,
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 46,
    parameter int IFG_LEN      = 12,
    parameter int SYNC_STAGES  = 3
) (
    input  logic             clk,
    input  logic             rst,
    gmii_tx_framer_if.master bus,
    output logic             busy,
    output logic             underflow
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
`ifdef GMII_TX_FCS_EN
        FCS,
`endif
        IFG
    } state_t;

`ifdef GMII_TX_FCS_EN
    localparam state_t TAIL = FCS;
`else
    localparam state_t TAIL = IFG;
`endif

    localparam logic [LEN_W-1:0] PRE_LAST = LEN_W'(PREAMBLE_LEN - 1);
    localparam logic [LEN_W-1:0] IFG_LAST = LEN_W'(IFG_LEN - 1);
    localparam logic [LEN_W:0]   MIN_EXT  = (LEN_W + 1)'(MIN_PAYLOAD);

    state_t               state;
    state_t               state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                 rdy_s;
    logic                 ack_q;
    logic                 accept;
    logic [LEN_W-1:0]     rem_cnt;
    logic [LEN_W-1:0]     phase_cnt;
    logic [LEN_W:0]       pad_cnt;
    logic [LEN_W:0]       wc_ext;

    logic [7:0]           data_d;
    logic                 en_d;
    logic                 er_d;
    logic                 uf_d;
    logic                 rd_d;
    logic [7:0]           data_q;
    logic                 en_q;
    logic                 er_q;
    logic                 uf_q;

    assign rdy_s  = sync[SYNC_STAGES-1];
    assign accept = (state == IDLE) && rdy_s && !ack_q;
    assign busy   = (state != IDLE);
    assign wc_ext = {1'b0, bus.word_count};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
        end else begin
            state     <= state_next;
            phase_cnt <= (state_next != state) ? '0 : phase_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept) state_next = PREAMBLE;
            PREAMBLE: if (phase_cnt == PRE_LAST) state_next = SFD;
            SFD: begin
                if (rem_cnt != '0)      state_next = DATA;
                else if (pad_cnt != '0) state_next = PAD;
                else                    state_next = TAIL;
            end
            DATA:     if (rem_cnt == LEN_W'(1)) state_next = (pad_cnt != '0) ? PAD : TAIL;
            PAD:      if (pad_cnt == (LEN_W + 1)'(1)) state_next = TAIL;
`ifdef GMII_TX_FCS_EN
            FCS:      if (phase_cnt == LEN_W'(3)) state_next = IFG;
`endif
            IFG:      if (phase_cnt == IFG_LAST) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

`ifdef GMII_TX_FCS_EN
    logic [31:0] crc;
    logic [31:0] fcs;

    // Reflected CRC-32, one byte per call; the FCS is the complemented remainder.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign fcs = ~crc;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            crc <= '1;
        end else if (state == DATA || state == PAD) begin
            crc <= crc_next(crc, data_d);
        end
    end
`endif

    always_comb begin
        data_d = 8'h00;
        en_d   = 1'b0;
        er_d   = 1'b0;
        uf_d   = 1'b0;
        rd_d   = 1'b0;
        case (state)
            PREAMBLE: begin
                en_d   = 1'b1;
                data_d = 8'h55;
            end
            SFD: begin
                en_d   = 1'b1;
                data_d = 8'hD5;
            end
            DATA: begin
                en_d = 1'b1;
                if (!bus.fifo_empty) begin
                    rd_d   = 1'b1;
                    data_d = bus.fifo_data;
                end else begin
                    er_d = 1'b1;
                    uf_d = 1'b1;
                end
            end
            PAD: en_d = 1'b1;
`ifdef GMII_TX_FCS_EN
            FCS: begin
                en_d   = 1'b1;
                data_d = fcs[{phase_cnt[1:0], 3'b000} +: 8];
            end
`endif
            default: ;
        endcase
    end

    // Pad count is one bit wider so N > MIN_PAYLOAD clamps to zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= '0;
            ack_q   <= 1'b0;
            rem_cnt <= '0;
            pad_cnt <= '0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.word_count_ready};
            if (!rdy_s) begin
                ack_q <= 1'b0;
            end else if (accept) begin
                ack_q <= 1'b1;
            end
            if (accept) begin
                rem_cnt <= bus.word_count;
                pad_cnt <= (wc_ext < MIN_EXT) ? (MIN_EXT - wc_ext) : '0;
            end else begin
                if (state == DATA) rem_cnt <= rem_cnt - 1'b1;
                if (state == PAD)  pad_cnt <= pad_cnt - 1'b1;
            end
            data_q <= data_d;
            en_q   <= en_d;
            er_q   <= er_d;
            uf_q   <= uf_d;
        end
    end

    assign bus.fifo_rd        = rd_d;
    assign bus.word_count_ack = ack_q;
    assign bus.gmii_tx_data   = data_q;
    assign bus.gmii_tx_en     = en_q;
    assign bus.gmii_tx_er     = er_q;
    assign underflow          = uf_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Testbench for gmii_tx_framer: a frame-level model predicts every GMII beat and a
// single monitor compares the DUT against it; works with or without GMII_TX_FCS_EN.
module tb_gmii_tx_framer;

    localparam int LEN_W        = 11;
    localparam int PREAMBLE_LEN = 7;
    localparam int MIN_PAYLOAD  = 46;
    localparam int IFG_LEN      = 12;
    localparam int SYNC_STAGES  = 3;

`ifdef GMII_TX_FCS_EN
    localparam int L64  = 76;
    localparam int LMIN = 58;
`else
    localparam int L64  = 72;
    localparam int LMIN = 54;
`endif

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [7:0] data;
        logic       er;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic underflow;

    gmii_tx_framer_if #(.LEN_W(LEN_W)) bus();

    gmii_tx_framer #(
        .LEN_W(LEN_W), .PREAMBLE_LEN(PREAMBLE_LEN), .MIN_PAYLOAD(MIN_PAYLOAD),
        .IFG_LEN(IFG_LEN), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .underflow(underflow)
    );

    always #4 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t   exp_q[$];
    int      exp_len_q[$];
    logic [7:0] fifo_q[$];

    int pops = 0, stall_at = -1, stall_left = 0;
    logic rd_seen = 1'b0, empty_seen = 1'b1;

    bit in_frame = 1'b0;
    int en_cnt = 0, last_len = 0, gap_cnt = 0, gap_last = 0, frames_done = 0, uf_cnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] crc32(input byte_q_t q);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (q[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[k][b];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    // Expected beats of one frame: payload slots in [uf_at, uf_at+uf_len) are underflows.
    task automatic modelFrame(input byte_q_t src, input int n, input int uf_at, input int uf_len);
        byte_q_t body;
        int      k;
        int      total;
        beat_t   b;
        k = 0;
        total = 0;
        for (int i = 0; i < PREAMBLE_LEN; i++) begin
            b.data = 8'h55; b.er = 1'b0; exp_q.push_back(b); total++;
        end
        b.data = 8'hD5; b.er = 1'b0; exp_q.push_back(b); total++;
        for (int i = 0; i < n; i++) begin
            if (i >= uf_at && i < uf_at + uf_len) begin
                b.data = 8'h00; b.er = 1'b1;
            end else begin
                b.data = src[k]; b.er = 1'b0; k++;
            end
            body.push_back(b.data);
            exp_q.push_back(b); total++;
        end
        while (body.size() < MIN_PAYLOAD) begin
            body.push_back(8'h00);
            b.data = 8'h00; b.er = 1'b0; exp_q.push_back(b); total++;
        end
`ifdef GMII_TX_FCS_EN
        begin
            logic [31:0] c;
            c = crc32(body);
            for (int i = 0; i < 4; i++) begin
                b.data = c[8*i +: 8]; b.er = 1'b0; exp_q.push_back(b); total++;
            end
        end
`endif
        exp_len_q.push_back(total);
    endtask

    // FIFO model: first-word-fall-through with an optional forced-empty window.
    always @(negedge clk) begin
        rd_seen    = bus.fifo_rd;
        empty_seen = bus.fifo_empty;
    end

    always @(posedge clk) begin
        #1;
        if (rd_seen) begin
            checkOutput("fifo_rd_when_empty", 32'(empty_seen), 32'd0);
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pops++;
        end
        if (pops == stall_at && stall_left > 0) begin
            bus.fifo_empty = 1'b1;
            stall_left--;
        end else begin
            bus.fifo_empty = (fifo_q.size() == 0);
            bus.fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            in_frame = 1'b0;
            en_cnt   = 0;
        end else if (bus.gmii_tx_en) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                gap_last = gap_cnt;
                en_cnt   = 0;
            end
            en_cnt++;
            if (underflow) uf_cnt++;
            checkOutput("busy_in_frame", 32'(busy), 32'd1);
            checkOutput("beat_available", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                checkOutput("tx_data", 32'(bus.gmii_tx_data), 32'(b.data));
                checkOutput("tx_er", 32'(bus.gmii_tx_er), 32'(b.er));
                checkOutput("underflow", 32'(underflow), 32'(b.er));
            end
        end else begin
            if (in_frame) begin
                in_frame = 1'b0;
                last_len = en_cnt;
                frames_done++;
                gap_cnt = 0;
                checkOutput("frame_len_available", 32'(exp_len_q.size() > 0), 32'd1);
                if (exp_len_q.size() > 0) checkOutput("frame_len_model", 32'(en_cnt), 32'(exp_len_q.pop_front()));
            end
            gap_cnt++;
            checkOutput("idle_er_underflow", 32'({bus.gmii_tx_er, underflow}), 32'd0);
        end
    end

    task automatic applyStimulus(input int n, input bit chk);
        int edges;
        edges = 0;
        bus.word_count       = LEN_W'(n);
        bus.word_count_ready = 1'b1;
        while (edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (bus.word_count_ack) break;
        end
        checkOutput("ack_seen", 32'(bus.word_count_ack), 32'd1);
        if (chk) begin
            checkOutput("ack_latency", 32'(edges), 32'(SYNC_STAGES + 1));
            @(posedge clk); #1;
            checkOutput("first_preamble", 32'({bus.gmii_tx_en, bus.gmii_tx_data}), 32'h155);
        end
    endtask

    task automatic dropReady();
        int edges;
        edges = 0;
        bus.word_count_ready = 1'b0;
        while (edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (!bus.word_count_ack) break;
        end
        checkOutput("ack_clear_latency", 32'(edges), 32'(SYNC_STAGES + 1));
    endtask

    task automatic waitFrames(input int target);
        int c;
        c = 0;
        while (frames_done < target && c < 2000) begin
            @(negedge clk);
            c++;
        end
        checkOutput("frame_complete", 32'(frames_done >= target), 32'd1);
    endtask

    task automatic waitIdle();
        int c;
        c = 0;
        while (busy && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("returns_idle", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic runSingle(input int n, input int seed, input int uf_at, input int uf_len, input int len_lit);
        byte_q_t src;
        int      target;
        for (int i = 0; i < n - uf_len; i++) src.push_back(8'(seed + i * 7));
        foreach (src[i]) fifo_q.push_back(src[i]);
        pops = 0;
        uf_cnt = 0;
        stall_at = uf_at;
        stall_left = uf_len;
        modelFrame(src, n, uf_at, uf_len);
        target = frames_done + 1;
        applyStimulus(n, 1'b1);
        dropReady();
        waitFrames(target);
        checkOutput("frame_len", 32'(last_len), 32'(len_lit));
        // Underflowed slots occupy a payload byte without popping the FIFO.
        checkOutput("fifo_pops", 32'(pops), 32'(n - uf_len));
        checkOutput("underflow_pulses", 32'(uf_cnt), 32'(uf_len));
        stall_at = -1;
        waitIdle();
    endtask

    initial begin
        byte_q_t pin;
        byte_q_t src_a;
        byte_q_t src_b;
        int      target;
        int      bad;
        int      c;

        rst = 1'b1;
        bus.fifo_data        = 8'h00;
        bus.fifo_empty       = 1'b1;
        bus.word_count       = '0;
        bus.word_count_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tx_en", 32'(bus.gmii_tx_en), 32'd0);
        checkOutput("rst_tx_data", 32'(bus.gmii_tx_data), 32'd0);
        checkOutput("rst_tx_er", 32'(bus.gmii_tx_er), 32'd0);
        checkOutput("rst_ack", 32'(bus.word_count_ack), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_underflow", 32'(underflow), 32'd0);
        checkOutput("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        rst = 1'b0;

        pin = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        checkOutput("model_crc_check_value", crc32(pin), 32'hCBF43926);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] frame N=64, full FIFO");
        runSingle(64, 1, -1, 0, L64);
        $display("[TB] frame N=10, padded");
        runSingle(10, 8'h90, -1, 0, LMIN);
        $display("[TB] frame N=20, two-cycle FIFO stall");
        runSingle(20, 8'h40, 8, 2, LMIN);

        $display("[TB] back-to-back N=10 then N=20");
        for (int i = 0; i < 10; i++) src_a.push_back(8'(8'hA0 + i));
        for (int i = 0; i < 20; i++) src_b.push_back(8'(8'h10 + 3 * i));
        foreach (src_a[i]) fifo_q.push_back(src_a[i]);
        foreach (src_b[i]) fifo_q.push_back(src_b[i]);
        modelFrame(src_a, 10, -1, 0);
        modelFrame(src_b, 20, -1, 0);
        pops = 0;
        target = frames_done + 2;
        applyStimulus(10, 1'b1);
        dropReady();
        bus.word_count       = LEN_W'(20);
        bus.word_count_ready = 1'b1;
        bad = 0;
        c = 0;
        while (busy && c < 300) begin
            @(posedge clk); #1;
            c++;
            if (bus.word_count_ack) bad++;
        end
        checkOutput("no_ack_while_busy", 32'(bad), 32'd0);
        c = 0;
        while (!bus.word_count_ack && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("second_ack", 32'(bus.word_count_ack), 32'd1);
        dropReady();
        waitFrames(target);
        checkOutput("ifg_gap", 32'(gap_last), 32'(IFG_LEN + 1));
        checkOutput("frame2_len", 32'(last_len), 32'(LMIN));
        checkOutput("b2b_pops", 32'(pops), 32'd30);
        waitIdle();

        $display("[TB] reset during payload of N=100");
        src_a.delete();
        for (int i = 0; i < 100; i++) src_a.push_back(8'(i + 5));
        foreach (src_a[i]) fifo_q.push_back(src_a[i]);
        modelFrame(src_a, 100, -1, 0);
        pops = 0;
        applyStimulus(100, 1'b1);
        dropReady();
        c = 0;
        while (pops < 5 && c < 300) begin
            @(negedge clk);
            c++;
        end
        checkOutput("reached_byte5", 32'(pops), 32'd5);
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_len_q.delete();
        in_frame = 1'b0;
        en_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid_rst_tx_en", 32'(bus.gmii_tx_en), 32'd0);
        checkOutput("mid_rst_tx_data", 32'(bus.gmii_tx_data), 32'd0);
        checkOutput("mid_rst_tx_er", 32'(bus.gmii_tx_er), 32'd0);
        checkOutput("mid_rst_underflow", 32'(underflow), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        checkOutput("mid_rst_ack", 32'(bus.word_count_ack), 32'd0);
        fifo_q.delete();
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] fresh frame N=46 after reset");
        runSingle(46, 8'h22, -1, 0, LMIN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
